// File: rtl/ascon_pack.sv
// Shared ASCON definitions: tag geometry, permutation-state type and verifier FSM states.
// The helper builds the finalization tag from the permutation state and key.
package ascon_pack;

    localparam int unsigned TAG_W_C      = 128;
    localparam int unsigned TAG_WORD_W_C = 32;
    localparam int unsigned KEY_W_C      = 128;

    // Five 64-bit lanes of the ASCON permutation state.
    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        VERIFY_IDLE,
        VERIFY_RECV,
        VERIFY_DONE
    } type_verify_state;

    function automatic logic [TAG_W_C-1:0] compute_tag(
        input type_state           s,
        input logic [KEY_W_C-1:0]  key
    );
        return {s[3] ^ key[127:64], s[4] ^ key[63:0]};
    endfunction

endpackage

// File: rtl/ascon_tag_verify.sv
// Constant-time comparison of a computed ASCON tag against a received tag word stream.
// Every word is consumed and differences are OR-accumulated; the verdict follows a one-cycle DONE.
module ascon_tag_verify
    import ascon_pack::*;
#(
    parameter int unsigned TAG_W  = TAG_W_C,
    parameter int unsigned WORD_W = TAG_WORD_W_C
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [TAG_W-1:0]  tag_calc_i,
    input  logic              abort_i,
    input  logic [WORD_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              tag_ok_o,
    output logic              tag_fail_o
);

    localparam int unsigned NB_WORDS = TAG_W / WORD_W;
    localparam int unsigned CNT_W    = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_WORDS - 1);

    if ((TAG_W % WORD_W) != 0 || NB_WORDS == 0) begin : g_bad_geometry
        $error("TAG_W must be a non-zero multiple of WORD_W");
    end

    type_verify_state state, state_next;

    logic [TAG_W-1:0]  tag_reg, tag_reg_next;
    logic [WORD_W-1:0] diff, diff_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              tag_ok, tag_ok_next;
    logic              tag_fail, tag_fail_next;

    logic                           xfer;
    logic [NB_WORDS-1:0][WORD_W-1:0] tag_words;
    logic [WORD_W-1:0]              ref_word;

    // Word 0 is the most significant slice of the tag.
    assign tag_words = tag_reg;
    assign ref_word  = tag_words[LAST_CNT - cnt];

    assign xfer = (state == VERIFY_RECV) && rx_valid_i;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state    <= VERIFY_IDLE;
            tag_reg  <= '0;
            diff     <= '0;
            cnt      <= '0;
            tag_ok   <= 1'b0;
            tag_fail <= 1'b0;
        end else begin
            state    <= state_next;
            tag_reg  <= tag_reg_next;
            diff     <= diff_next;
            cnt      <= cnt_next;
            tag_ok   <= tag_ok_next;
            tag_fail <= tag_fail_next;
        end
    end

    always_comb begin
        state_next    = state;
        tag_reg_next  = tag_reg;
        diff_next     = diff;
        cnt_next      = cnt;
        tag_ok_next   = tag_ok;
        tag_fail_next = tag_fail;

        unique case (state)
            VERIFY_IDLE: begin
                if (start_i && !abort_i) begin
                    tag_reg_next  = tag_calc_i;
                    diff_next     = '0;
                    cnt_next      = '0;
                    tag_ok_next   = 1'b0;
                    tag_fail_next = 1'b0;
                    state_next    = VERIFY_RECV;
                end
            end

            VERIFY_RECV: begin
                if (abort_i) begin
                    tag_reg_next  = '0;
                    diff_next     = '0;
                    cnt_next      = '0;
                    tag_ok_next   = 1'b0;
                    tag_fail_next = 1'b0;
                    state_next    = VERIFY_IDLE;
                end else if (xfer) begin
                    diff_next = diff | (rx_data_i ^ ref_word);
                    if (cnt == LAST_CNT) begin
                        cnt_next   = '0;
                        state_next = VERIFY_DONE;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
            end

            VERIFY_DONE: begin
                if (abort_i) begin
                    tag_ok_next   = 1'b0;
                    tag_fail_next = 1'b0;
                end else begin
                    tag_ok_next   = (diff == '0);
                    tag_fail_next = (diff != '0);
                end
                // Secrets do not linger once the verdict is taken.
                tag_reg_next = '0;
                diff_next    = '0;
                cnt_next     = '0;
                state_next   = VERIFY_IDLE;
            end

            default: begin
                tag_reg_next  = '0;
                diff_next     = '0;
                cnt_next      = '0;
                tag_ok_next   = 1'b0;
                tag_fail_next = 1'b0;
                state_next    = VERIFY_IDLE;
            end
        endcase
    end

    assign rx_ready_o = (state == VERIFY_RECV);
    assign busy_o     = (state == VERIFY_RECV) || (state == VERIFY_DONE);
    assign done_o     = (state == VERIFY_DONE) && !abort_i;
    assign tag_ok_o   = tag_ok;
    assign tag_fail_o = tag_fail;

endmodule

// File: tb/tb_ascon_tag_verify.sv
// Scoreboard bench for ascon_tag_verify: stimulus pushes expected verdicts, a monitor checks them.
module tb_ascon_tag_verify;
    import ascon_pack::*;

    logic         clock      = 1'b0;
    logic         reset      = 1'b1;
    logic         start      = 1'b0;
    logic [127:0] tag_calc   = '0;
    logic         abort      = 1'b0;
    logic [31:0]  rx_data    = '0;
    logic         rx_valid   = 1'b0;
    logic         rx_ready;
    logic         busy;
    logic         done;
    logic         tag_ok;
    logic         tag_fail;

    ascon_tag_verify #(
        .TAG_W  (128),
        .WORD_W (32)
    ) dut (
        .clock_i    (clock),
        .reset_i    (reset),
        .start_i    (start),
        .tag_calc_i (tag_calc),
        .abort_i    (abort),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready),
        .busy_o     (busy),
        .done_o     (done),
        .tag_ok_o   (tag_ok),
        .tag_fail_o (tag_fail)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int done_cyc;
        bit ok;
    } exp_t;
    typedef logic [31:0] words_t [4];

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [127:0] TAG_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] TAG_B = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Start a run; pat_len is the number of RECV cycles the stimulus will spend.
    task automatic do_start(input logic [127:0] tag, input int pat_len, input bit ok);
        exp_t e;
        e.done_cyc = cyc + 1 + pat_len;
        e.ok       = ok;
        sb.push_back(e);
        start    = 1'b1;
        tag_calc = tag;
        tick();
        start    = 1'b0;
        tag_calc = '0;
    endtask

    // pat bit i drives rx_valid in the i-th RECV cycle; invalid cycles carry junk data.
    task automatic send(input words_t w, input logic [15:0] pat, input int len);
        int idx = 0;
        for (int i = 0; i < len; i++) begin
            rx_valid = pat[i];
            rx_data  = pat[i] ? w[idx] : 32'hDEADBEEF;
            if (pat[i]) idx++;
            tick();
        end
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    // Monitor: every done_o pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_o=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", 128'(cyc), 128'(e.done_cyc));
                    tick();
                    check("verdict_ok", 128'(tag_ok), 128'(e.ok));
                    check("verdict_fail", 128'(tag_fail), 128'(!e.ok));
                end
            end
        end
    end

    initial begin
        words_t wa;
        words_t wbad;
        wa = '{32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};

        tick();
        tick();
        reset = 1'b0;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_ready", 128'(rx_ready), 128'(0));
        check("rst_ok", 128'(tag_ok), 128'(0));
        check("rst_fail", 128'(tag_fail), 128'(0));

        // Matching tag, back-to-back words.
        do_start(TAG_A, 4, 1'b1);
        check("recv_ready", 128'(rx_ready), 128'(1));
        check("recv_busy", 128'(busy), 128'(1));
        send(wa, 16'h000F, 4);
        check("done_ready_low", 128'(rx_ready), 128'(0));
        check("done_busy", 128'(busy), 128'(1));
        tick();
        check("idle_ready_low", 128'(rx_ready), 128'(0));
        tick();

        // Mismatch in MSB of first word, then LSB of last word: same latency.
        wbad = wa;
        wbad[0] = wbad[0] ^ 32'h8000_0000;
        do_start(TAG_A, 4, 1'b0);
        send(wbad, 16'h000F, 4);
        tick();
        tick();
        wbad = wa;
        wbad[3] = wbad[3] ^ 32'h0000_0001;
        do_start(TAG_A, 4, 1'b0);
        send(wbad, 16'h000F, 4);
        tick();
        tick();

        // Back-pressure: valid 1,0,0,1,1,0,1.
        do_start(TAG_A, 7, 1'b1);
        send(wa, 16'b1011001, 7);
        check("bp_done_ready_low", 128'(rx_ready), 128'(0));
        tick();
        tick();

        // Start together with abort in IDLE is ignored.
        start    = 1'b1;
        abort    = 1'b1;
        tag_calc = TAG_B;
        tick();
        start    = 1'b0;
        abort    = 1'b0;
        check("start_abort_idle", 128'(busy), 128'(0));
        check("start_abort_keep_ok", 128'(tag_ok), 128'(1));

        // Abort alongside the second valid word.
        start    = 1'b1;
        tag_calc = TAG_A;
        tick();
        start    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = wa[0];
        tick();
        rx_data  = wa[1];
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        rx_valid = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_ready", 128'(rx_ready), 128'(0));
        check("abort_ok", 128'(tag_ok), 128'(0));
        check("abort_fail", 128'(tag_fail), 128'(0));
        tick();
        tick();
        do_start(TAG_A, 4, 1'b1);
        send(wa, 16'h000F, 4);
        tick();
        tick();

        // Reset after two mismatching words must leave no stale difference.
        start    = 1'b1;
        tag_calc = TAG_A;
        tick();
        start    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 32'hFFFF_FFFF;
        tick();
        tick();
        rx_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_ready", 128'(rx_ready), 128'(0));
        check("mid_rst_done", 128'(done), 128'(0));
        check("mid_rst_ok", 128'(tag_ok), 128'(0));
        check("mid_rst_fail", 128'(tag_fail), 128'(0));
        do_start(TAG_A, 4, 1'b1);
        send(wa, 16'h000F, 4);
        tick();
        tick();

        // start_i in RECV with another tag must not relatch.
        do_start(TAG_A, 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = wa[i];
            start    = (i == 1);
            tag_calc = (i == 1) ? TAG_B : '0;
            tick();
        end
        start    = 1'b0;
        tag_calc = '0;
        rx_valid = 1'b0;
        tick();
        tick();

        tick();
        tick();
        check("scoreboard_empty", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ascon_tag_verify.md
Name: ascon_tag_verify

Overview:
- Receive-side counterpart of the finalization stage.
- Finalization produces the computed tag as state[3]^K[127:64] concatenated with state[4]^K[63:0]. This block takes that tag and compares it with the received tag, which arrives as a word stream over a valid/ready handshake.
- Comparison is constant-time: all words are always consumed and differences are OR-accumulated, so the pass/fail result never depends on where a mismatch occurs.
- Sits between the ASCON decryption datapath/FSM and the external tag input interface.

Parameters:
- TAG_W, 128, tag width in bits; must be a multiple of WORD_W.
- WORD_W, 32, received-tag word width; NB_WORDS = TAG_W/WORD_W (default 4).

Ports:
- clock_i  input  1  system clock, rising edge
- reset_i  input  1  synchronous, active-high reset
- start_i  input  1  one-cycle pulse; latch tag_calc_i and begin reception (honoured in IDLE only)
- tag_calc_i  input  TAG_W  computed tag {state[3]^K_hi, state[4]^K_lo}; sampled only on accepted start_i
- abort_i  input  1  cancel an in-progress verification
- rx_data_i  input  WORD_W  received tag word, MSB word first
- rx_valid_i  input  1  rx_data_i valid
- rx_ready_o  output  1  block can accept a word
- busy_o  output  1  high in RECV and DONE
- done_o  output  1  one-cycle pulse; verdict valid
- tag_ok_o  output  1  tags equal; held until next accepted start_i, abort_i or reset
- tag_fail_o  output  1  tags differ; held like tag_ok_o; never high together with tag_ok_o

Behaviour:
- Reset (synchronous, active-high, on clock_i):
  - State = IDLE; all outputs 0.
  - Word counter 0, diff accumulator 0, tag register 0.
  - Reset asserted mid-operation discards everything; no done_o is produced.
- States:
  - IDLE:
    - start_i=1 and abort_i=0 -> tag_reg <= tag_calc_i, cnt <= 0, diff <= 0, tag_ok_o/tag_fail_o <= 0, next state RECV.
    - start_i=1 and abort_i=1 in the same cycle -> start ignored, stay IDLE.
  - RECV:
    - rx_ready_o=1 (decoded from state; no combinational path from rx_valid_i).
    - A transfer occurs when rx_valid_i && rx_ready_o.
    - On a transfer: diff <= diff | (rx_data_i ^ tag_reg[TAG_W-1-cnt*WORD_W -: WORD_W]); cnt <= cnt+1.
    - Transfer with cnt==NB_WORDS-1 -> next state DONE.
    - rx_valid_i low -> wait indefinitely (no timeout).
    - start_i is ignored.
  - DONE (exactly one cycle):
    - done_o=1, rx_ready_o=0.
    - tag_ok_o <= (diff==0); tag_fail_o <= (diff!=0).
    - tag_reg and diff zeroized.
    - Next state IDLE.
- Verdict timing:
  - tag_ok_o/tag_fail_o take their new value on the edge that leaves DONE, i.e. they are visible the cycle after the done_o pulse.
  - Minimum latency from start_i to done_o is NB_WORDS+1 cycles.
- abort_i:
  - In RECV or DONE: next state IDLE; tag_reg, diff and cnt zeroized; tag_ok_o = tag_fail_o = 0; done_o is not asserted.
  - Abort takes priority over a simultaneous rx transfer; that word is not consumed-counted.
  - abort_i in IDLE without start_i has no effect.
- Constant time: cycle count depends only on the rx_valid_i pattern, never on data. No early exit on mismatch.
- Counter width: $clog2(NB_WORDS); no wrap is reachable because the last transfer forces DONE.
- rx_data_i and rx_valid_i are ignored outside RECV.

Decomposition:
- Add to ascon_pack:
  - localparams TAG_W_C=128 and TAG_WORD_W_C=32.
  - typedef enum logic [1:0] {VERIFY_IDLE, VERIFY_RECV, VERIFY_DONE} type_verify_state.
- Single module; no sub-module needed. Word selection and the diff accumulator are small enough to live inline.
- Reuses the existing type_state only at the integration level, where the tag is built from state_o[3]/[4] of the finalization XOR.

Test Plan:
- Match: start_i with tag_calc_i=128'h0123456789ABCDEF_FEDCBA9876543210; words 01234567, 89ABCDEF, FEDCBA98, 76543210 on consecutive cycles -> done_o pulse 5 cycles after start; then tag_ok_o=1, tag_fail_o=0.
- Mismatch in first vs last word: flip bit 31 of word 0, then separately bit 0 of word 3 -> tag_fail_o=1 both runs; done_o at the identical cycle offset in both (constant time).
- Back-pressure: rx_valid_i toggles 1,0,0,1,1,0,1 carrying the matching tag -> exactly 4 transfers counted; done_o the cycle after the 4th; tag_ok_o=1; rx_ready_o low in IDLE/DONE.
- Abort: abort_i asserted together with the 2nd valid word -> no done_o; IDLE next cycle; ok=fail=0. A fresh start with a matching tag then passes.
- Reset mid-RECV: reset_i pulsed after 2 words -> all outputs 0 next cycle; rx_ready_o=0; a subsequent full run verifies correctly (no stale diff).
- Ignored start: start_i pulsed in RECV with a different tag_calc_i -> comparison still uses the originally latched tag; verdict unchanged.
